logs_sweep_ctrl: RTL and testbench

LOGS_SWEEP_CTRL -- requirements
Module: logs_sweep_ctrl

---
 rtl/logs_sweep_ctrl.sv | 167 ++++++++++++++++
 tb/tb_logs_sweep_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/logs_sweep_ctrl.sv
// Sweep controller for the logistic-map sonifier: steps r through its range,
// discards each r's transient iterations, and routes later x samples round-robin
// into the active oscillator slots. The slot set shrinks inside the
// period-5/period-6 windows.
module logs_sweep_ctrl #(
   parameter int unsigned FRAC    = 8,
   parameter int unsigned N_OSC   = 4,
   parameter int unsigned R_INC   = 1000,
   parameter int unsigned SETTLE  = 64,
   parameter int unsigned R_START = (1 << FRAC) | (1 << (FRAC - 4)),
   localparam int unsigned IDX_W  = (N_OSC > 1) ? $clog2(N_OSC) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              next_ready,
   input  logic              pause,
   input  logic              step_req,
   output logic [FRAC+1:0]   r,
   output logic              wr_en,
   output logic [IDX_W-1:0]  wr_idx,
   output logic [N_OSC-1:0]  osc_mask,
   output logic              mute
);

   localparam int unsigned RW    = FRAC + 2;
   localparam int unsigned IT_W  = (R_INC > 1) ? $clog2(R_INC) : 1;
   localparam int unsigned CNT_W = $clog2(N_OSC + 1);
   localparam int unsigned N5    = (N_OSC < 5) ? N_OSC : 5 * (N_OSC / 5);
   localparam int unsigned N6    = (N_OSC < 6) ? N_OSC : 6 * (N_OSC / 6);
   localparam logic [RW-1:0] R_RST = RW'(R_START);

   typedef enum logic [1:0] {
      ST_SETTLE = 2'd0,
      ST_PLAY   = 2'd1,
      ST_PAUSED = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [RW-1:0]        r_q, r_d;
   logic [IT_W-1:0]      iter_q, iter_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
   logic                 wr_en_q, wr_en_d;
   logic                 mute_q;
   logic [N_OSC-1:0]     mask_q;
   logic [CNT_W-1:0]     act_q, act_d;

   // Active slot count from the top eight bits of r (two integer, six fraction).
   function automatic logic [CNT_W-1:0] act_of(input logic [7:0] top);
      if (top == 8'b11101000 || (top[7:2] == 6'b111101 && top[1:0] != 2'b11))
         return CNT_W'(N6);
      else if (top[7:1] == 7'b1110111)
         return CNT_W'(N5);
      else
         return CNT_W'(N_OSC);
   endfunction

   // Thermometer mask with the n low bits set.
   function automatic logic [N_OSC-1:0] mask_of(input logic [CNT_W-1:0] n);
      logic [N_OSC-1:0] m;
      m = '0;
      for (int i = 0; i < N_OSC; i++) begin
         if (CNT_W'(i) < n) m[i] = 1'b1;
      end
      return m;
   endfunction

   // Coarse steps below r=3.0, fine steps in the chaotic region, wrap at the top.
   function automatic logic [RW-1:0] r_adv(input logic [RW-1:0] rv);
      if (&rv)
         return R_RST;
      else if (rv[FRAC+1:FRAC] < 2'd3)
         return rv + RW'(4);
      else
         return rv + RW'(1);
   endfunction

   // Next-state, counters and write strobe.
   always_comb begin
      state_d  = state_q;
      r_d      = r_q;
      iter_d   = iter_q;
      idx_d    = idx_q;
      wr_en_d  = 1'b0;
      wr_idx_d = idx_q;
      if (pause && state_q != ST_PAUSED) begin
         state_d = ST_PAUSED;
      end else begin
         case (state_q)
            ST_SETTLE: begin
               if (SETTLE == 0) begin
                  state_d = ST_PLAY;
               end else if (next_ready) begin
                  iter_d = iter_q + IT_W'(1);
                  if (iter_q + IT_W'(1) == IT_W'(SETTLE)) state_d = ST_PLAY;
               end
            end
            ST_PLAY: begin
               if (next_ready) begin
                  wr_en_d = 1'b1;
                  if (iter_q == IT_W'(R_INC - 1)) begin
                     iter_d  = '0;
                     idx_d   = '0;
                     r_d     = r_adv(r_q);
                     state_d = ST_SETTLE;
                  end else begin
                     iter_d = iter_q + IT_W'(1);
                     if (CNT_W'(idx_q) + CNT_W'(1) >= act_q) idx_d = '0;
                     else                                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
            ST_PAUSED: begin
               if (step_req) begin
                  r_d    = r_adv(r_q);
                  iter_d = '0;
                  idx_d  = '0;
               end
               if (!pause) begin
                  state_d = ST_SETTLE;
                  iter_d  = '0;
               end
            end
            default: state_d = ST_SETTLE;
         endcase
      end
      // Written slot while strobing, otherwise the upcoming slot.
      if (!wr_en_d) wr_idx_d = idx_d;
   end

   // Slot configuration follows the r that is about to be registered.
   always_comb begin
      act_d = act_of(r_d[FRAC+1:FRAC-6]);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_SETTLE;
         r_q      <= R_RST;
         iter_q   <= '0;
         idx_q    <= '0;
         wr_idx_q <= '0;
         wr_en_q  <= 1'b0;
         mute_q   <= 1'b1;
         act_q    <= act_of(R_RST[FRAC+1:FRAC-6]);
         mask_q   <= mask_of(act_of(R_RST[FRAC+1:FRAC-6]));
      end else begin
         state_q  <= state_d;
         r_q      <= r_d;
         iter_q   <= iter_d;
         idx_q    <= idx_d;
         wr_idx_q <= wr_idx_d;
         wr_en_q  <= wr_en_d;
         mute_q   <= (state_d != ST_PLAY);
         act_q    <= act_d;
         mask_q   <= mask_of(act_d);
      end
   end

   assign r        = r_q;
   assign wr_en    = wr_en_q;
   assign wr_idx   = wr_idx_q;
   assign osc_mask = mask_q;
   assign mute     = mute_q;

endmodule

// File: tb/tb_logs_sweep_ctrl.sv
// Randomised bench for logs_sweep_ctrl: a pulse-counting reference model
// predicts r, mask and mute each cycle; expected slot writes go through a
// scoreboard queue drained by an independent monitor.
module tb_logs_sweep_ctrl;

   localparam int FRAC     = 8;
   localparam int N_OSC    = 6;
   localparam int R_INC    = 8;
   localparam int SETTLE_N = 2;
   localparam int R_ST     = 'h110;
   localparam int M_SETTLE = 0;
   localparam int M_PLAY   = 1;
   localparam int M_PAUSED = 2;

   logic       clk = 1'b0;
   logic       reset, next_ready, pause, step_req;
   logic [9:0] r;
   logic       wr_en;
   logic [2:0] wr_idx;
   logic [5:0] osc_mask;
   logic       mute;

   always #5 clk = ~clk;

   logs_sweep_ctrl #(
      .FRAC(FRAC), .N_OSC(N_OSC), .R_INC(R_INC), .SETTLE(SETTLE_N)
   ) dut (
      .clk(clk), .reset(reset), .next_ready(next_ready), .pause(pause),
      .step_req(step_req), .r(r), .wr_en(wr_en), .wr_idx(wr_idx),
      .osc_mask(osc_mask), .mute(mute)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int idx;
      int due;
   } wr_t;
   wr_t sbq[$];

   int m_r, m_mode, m_cnt, m_slot;
   bit m_wrote;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Number of usable oscillators for an r value, from the window tables.
   function automatic int act_of(input int rv);
      int n5, n6;
      n5 = (N_OSC < 5) ? N_OSC : 5 * (N_OSC / 5);
      n6 = (N_OSC < 6) ? N_OSC : 6 * (N_OSC / 6);
      if ((rv >= 'h3A0 && rv <= 'h3A3) || (rv >= 'h3D0 && rv <= 'h3DB)) return n6;
      if (rv >= 'h3B8 && rv <= 'h3BF) return n5;
      return N_OSC;
   endfunction

   function automatic int adv(input int rv);
      if (rv == 'h3FF) return R_ST;
      if (rv < 'h300) return rv + 4;
      return rv + 1;
   endfunction

   // Reference behaviour for one clock edge with the given inputs.
   task automatic model_step(input bit rst, input bit nr, input bit ps, input bit st);
      m_wrote = 1'b0;
      if (rst) begin
         m_r = R_ST; m_mode = M_SETTLE; m_cnt = 0; m_slot = 0;
      end else if (ps && m_mode != M_PAUSED) begin
         m_mode = M_PAUSED;
      end else if (m_mode == M_PAUSED) begin
         if (st) begin
            m_r = adv(m_r); m_cnt = 0; m_slot = 0;
         end
         if (!ps) begin
            m_mode = M_SETTLE; m_cnt = 0;
         end
      end else if (nr && m_mode == M_SETTLE) begin
         m_cnt++;
         if (m_cnt == SETTLE_N) m_mode = M_PLAY;
      end else if (nr && m_mode == M_PLAY) begin
         sbq.push_back('{idx: m_slot, due: cyc + 1});
         m_wrote = 1'b1;
         if (m_cnt == R_INC - 1) begin
            m_cnt = 0; m_slot = 0; m_r = adv(m_r); m_mode = M_SETTLE;
         end else begin
            m_cnt++;
            m_slot = (m_slot + 1) % act_of(m_r);
         end
      end
   endtask

   // Check registered outputs, apply inputs for the next edge, advance past it.
   task automatic cycle(input bit rst, input bit nr, input bit ps, input bit st);
      check("r", int'(r), m_r);
      check("osc_mask", int'(osc_mask), (1 << act_of(m_r)) - 1);
      check("mute", int'(mute), (m_mode != M_PLAY) ? 1 : 0);
      if (!m_wrote) check("wr_idx_idle", int'(wr_idx), m_slot);
      reset = rst; next_ready = nr; pause = ps; step_req = st;
      model_step(rst, nr, ps, st);
      @(posedge clk);
      #2;
   endtask

   task automatic step_until(input int target);
      int n;
      n = 0;
      while (m_r != target && n < 600) begin
         cycle(0, 0, 1, 1);
         n++;
      end
      check("step_reach", m_r, target);
   endtask

   // Scoreboard monitor: every strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         if (sbq.size() == 0) begin
            check("wr_unexpected", 1, 0);
         end else begin
            wr_t e;
            e = sbq.pop_front();
            check("wr_idx", int'(wr_idx), e.idx);
            check("wr_time", cyc, e.due);
         end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
         check("wr_missing", 0, 1);
         void'(sbq.pop_front());
      end
   end

   initial begin
      bit ps_lvl;
      reset = 1'b1; next_ready = 1'b0; pause = 1'b0; step_req = 1'b0;
      model_step(1, 0, 0, 0);
      @(posedge clk);
      #2;
      cycle(1, 0, 0, 0);

      // Settle, then six writes, then the r advance.
      for (int i = 0; i < 8; i++) begin
         cycle(0, 1, 0, 0);
         cycle(0, 0, 0, 0);
      end
      check("r_after_8", int'(r), 'h114);
      check("mute_after_8", int'(mute), 1);

      // Pause colliding with a pulse, then a step while running.
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 1, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 1);
      check("step_ignored", int'(r), 'h114);

      // Period-5 window: only five slots rotate.
      cycle(0, 0, 1, 0);
      step_until('h3B8);
      cycle(0, 0, 1, 0);
      check("mask_p5", int'(osc_mask), 'h1F);
      for (int i = 0; i < 9; i++) begin
         cycle(0, 1, 0, 0);
         cycle(0, 0, 0, 0);
      end

      // Wrap at the top and the coarse/fine step boundary.
      cycle(0, 0, 1, 0);
      step_until('h3FF);
      cycle(0, 0, 1, 1);
      check("r_wrap", int'(r), 'h110);
      step_until('h2FC);
      cycle(0, 0, 1, 1);
      check("r_2fc", int'(r), 'h300);
      cycle(0, 0, 1, 1);
      check("r_300", int'(r), 'h301);
      step_until('h3A0);
      cycle(0, 0, 1, 0);
      check("mask_p6", int'(osc_mask), 'h3F);

      // Reset right after a write is triggered.
      cycle(0, 0, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(1, 0, 0, 0);
      check("rst_wr_en", int'(wr_en), 0);
      check("rst_r", int'(r), R_ST);
      check("rst_mute", int'(mute), 1);
      check("rst_idx", int'(wr_idx), 0);

      // Random traffic.
      ps_lvl = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         bit rst, nr, st;
         if ($urandom_range(99) < 3) ps_lvl = ~ps_lvl;
         rst = ($urandom_range(199) == 0);
         nr  = ($urandom_range(2) == 0);
         st  = ps_lvl ? ($urandom_range(3) == 0) : ($urandom_range(19) == 0);
         cycle(rst, nr, ps_lvl, st);
      end

      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      @(negedge clk);
      #1;
      check("sb_empty", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
